tcpc_reset_ctrl: RTL
====================

// Module: tcpc_reset_ctrl
// PURPOSE
//  Parametrised hard-reset / cable-reset sequencer for the TCPC register block.
//  - Decodes TRANSMIT register writes and clears the receive registers.
//  - Drives a request to the PHY and waits for PHY_ACK, with timeout and bounded retries.
//  - Reports success, failure or discard in ALERT, and signals PHY_Stop_Attempting_Reset when retries are exhausted.
//  - Sits between the register file and the PHY layer.
// PARAMETERS
//  TO_W      default 8   width of ack-timeout counter
//  TO_CYC    default 200 cycles to wait for PHY_ACK per attempt (1..2^TO_W-1)
//  N_RETRY   default 2   extra attempts after the first (0..7)
//  CNT_W     default 8   width of RECEIVE_BYTE_COUNT
// PORTS
//  CLK                        in   1      system clock, rising edge
//  reset                      in   1      synchronous, active-high
//  iTRANSMIT_WE               in   1      1-cycle write strobe for TRANSMIT
//  ioTRANSMIT                 in   8      TRANSMIT write data; [2:0] = command
//  PHY_ACK                    in   1      PHY completed reset signalling (1-cycle pulse)
//  iALERT_CLR                 in   16     write-1-to-clear mask for ALERT
//  oTRANSMIT                  out  8      TRANSMIT register readback
//  PHY_REQ                    out  1      1-cycle request pulse to PHY
//  PHY_REQ_TYPE               out  1      0 = hard reset, 1 = cable reset
//  PHY_Stop_Attempting_Reset  out  1      1-cycle pulse on final failure
//  ALERT                      out  16     sticky alert register
//  oRECEIVE_DETECT            out  8      cleared to 0 on accepted reset
//  oRECEIVE_BYTE_COUNT        out  CNT_W  cleared to 0 on accepted reset
//  oBUSY                      out  1      high in any non-IDLE state
// BEHAVIOUR
//  - Reset: synchronous, active-high, evaluated at the CLK edge.
//    - All outputs are 0 on the cycle after reset is sampled high.
//    - oRECEIVE_DETECT resets to 8'h00. oRECEIVE_BYTE_COUNT resets to 0.
//    - Reset mid-sequence aborts immediately. No alert is set and no stop pulse is generated.
//  - oTRANSMIT latches ioTRANSMIT on every iTRANSMIT_WE.
//  - Accepted commands: [2:0] = 3'b101 (hard reset) and 3'b110 (cable reset). Other codes are latched only.
//  - FSM states: IDLE, CLEAR, REQ, WAIT_ACK, DONE_OK, DONE_FAIL.
//    - IDLE: accepted command with WE -> CLEAR. Store the type, retry_cnt = 0.
//    - CLEAR: zero oRECEIVE_DETECT and oRECEIVE_BYTE_COUNT, then go to REQ.
//    - REQ: PHY_REQ = 1 for 1 cycle, PHY_REQ_TYPE valid in the same cycle. Load timer = TO_CYC. Go to WAIT_ACK.
//    - WAIT_ACK, PHY_ACK = 1 -> DONE_OK. PHY_ACK has priority over timeout expiry in the same cycle.
//    - WAIT_ACK, timer reaches 0: if retry_cnt < N_RETRY, then retry_cnt++ and go to REQ. Otherwise go to DONE_FAIL.
//    - DONE_OK: set ALERT[6] (Tx success), then go to IDLE.
//    - DONE_FAIL: set ALERT[4] (Tx failed) and pulse PHY_Stop_Attempting_Reset, then go to IDLE.
//  - Latency and timing:
//    - WE to first PHY_REQ = 2 cycles.
//    - PHY_ACK to ALERT[6] visible = 2 cycles.
//    - Maximum attempts = N_RETRY + 1.
//  - An accepted command while oBUSY = 1 is discarded. ALERT[5] is set the next cycle and the sequence continues.
//  - PHY_ACK outside WAIT_ACK is ignored.
//  - ALERT is sticky.
//    - Bit clears when iALERT_CLR[i] = 1.
//    - If set and clear of the same bit occur in the same cycle, the set wins.
//    - Unused ALERT bits are held at 0.
//  - The timer decrements with saturation at 0 and does not wrap.
// STRUCTURE
//  - Shared include tcpc_defs.vh:
//    - TRANSMIT command codes (CMD_HARD_RST = 3'b101, CMD_CABLE_RST = 3'b110)
//    - ALERT bit indices (AL_TX_FAIL = 4, AL_TX_DISC = 5, AL_TX_OK = 6)
//    - FSM state encodings
//  - One sub-module, tcpc_timeout_cnt (load, decrement, expired flag, parameter TO_W). The FSM stays in the top.
// TESTING
//  - Hard reset, ACK 5 cycles after PHY_REQ:
//    - WE with ioTRANSMIT = 8'h05 -> PHY_REQ at +2 with PHY_REQ_TYPE = 0.
//    - Receive registers are 0 by then. ALERT = 16'h0040.
//  - Cable reset, no ACK, N_RETRY = 2, TO_CYC = 10:
//    - ioTRANSMIT = 8'h06 -> 3 PHY_REQ pulses spaced 11 cycles apart.
//    - Then ALERT[4] = 1 and one PHY_Stop_Attempting_Reset pulse.
//  - Second write of 8'h05 while oBUSY = 1 -> ALERT[5] = 1 and only one sequence runs.
//  - PHY_ACK in the same cycle as timer expiry -> DONE_OK, with no retry.
//  - reset asserted during WAIT_ACK -> all outputs 0 the next cycle, ALERT = 0, no stop pulse.
//  - iALERT_CLR = 16'h0040 after success -> ALERT = 0. Clear and set in the same cycle -> bit stays 1.

Source files
------------

// File: rtl/tcpc_reset_ctrl_pkg.sv
// Shared definitions for the TCPC hard/cable reset sequencer: command codes,
// ALERT bit positions and FSM state encodings.
package tcpc_reset_ctrl_pkg;

    localparam logic [2:0] CMD_HARD_RST  = 3'b101;
    localparam logic [2:0] CMD_CABLE_RST = 3'b110;

    localparam int AL_TX_FAIL = 4;
    localparam int AL_TX_DISC = 5;
    localparam int AL_TX_OK   = 6;

    // Only the three transmit-status bits exist in this block; the rest read 0.
    localparam logic [15:0] ALERT_USED_MASK = 16'h0070;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_CLEAR     = 3'd1;
    localparam state_t ST_REQ       = 3'd2;
    localparam state_t ST_WAIT_ACK  = 3'd3;
    localparam state_t ST_DONE_OK   = 3'd4;
    localparam state_t ST_DONE_FAIL = 3'd5;

    function automatic logic is_reset_cmd(input logic [2:0] cmd);
        return (cmd == CMD_HARD_RST) || (cmd == CMD_CABLE_RST);
    endfunction

endpackage

// File: rtl/tcpc_timeout_cnt.sv
// Purpose: loadable down-counter for the PHY_ACK timeout, saturating at zero.
// Latency: expired is combinational from the count; load/decrement take effect next cycle.
// Backpressure: none; decrements whenever dec is high.
module tcpc_timeout_cnt #(
    parameter int TO_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [TO_W-1:0] load_val,
    input  logic            dec,
    output logic            expired
);

    logic [TO_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - TO_W'(1);
        end
    end

    // Flags the cycle on which the count steps down to zero, so a load of N
    // gives exactly N waiting cycles.
    assign expired = (cnt_q == TO_W'(1)) || (cnt_q == '0);

endmodule

// File: rtl/tcpc_reset_ctrl.sv
// Purpose: sequences TCPC hard/cable resets: clears RX registers, requests the PHY, retries on timeout.
// Latency: TRANSMIT write to PHY_REQ is 2 cycles; PHY_ACK to ALERT[6] is 2 cycles.
// Backpressure: none; a reset command arriving while busy is dropped and flagged in ALERT[5].
module tcpc_reset_ctrl
    import tcpc_reset_ctrl_pkg::*;
#(
    parameter int TO_W    = 8,
    parameter int TO_CYC  = 200,
    parameter int N_RETRY = 2,
    parameter int CNT_W   = 8
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             iTRANSMIT_WE,
    input  logic [7:0]       ioTRANSMIT,
    input  logic             PHY_ACK,
    input  logic [15:0]      iALERT_CLR,
    output logic [7:0]       oTRANSMIT,
    output logic             PHY_REQ,
    output logic             PHY_REQ_TYPE,
    output logic             PHY_Stop_Attempting_Reset,
    output logic [15:0]      ALERT,
    output logic [7:0]       oRECEIVE_DETECT,
    output logic [CNT_W-1:0] oRECEIVE_BYTE_COUNT,
    output logic             oBUSY
);

    state_t      state_q, state_d;
    logic [2:0]  retry_q;
    logic        type_q;
    logic [15:0] alert_q;
    logic [15:0] alert_set;
    logic        accept_cmd;
    logic        retry_left;
    logic        tmr_expired;

    assign accept_cmd = iTRANSMIT_WE && is_reset_cmd(ioTRANSMIT[2:0]);
    assign retry_left = (retry_q < 3'(N_RETRY));

    tcpc_timeout_cnt #(
        .TO_W (TO_W)
    ) u_timeout (
        .clk      (CLK),
        .reset    (reset),
        .load     (state_q == ST_REQ),
        .load_val (TO_W'(TO_CYC)),
        .dec      (state_q == ST_WAIT_ACK),
        .expired  (tmr_expired)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (accept_cmd) state_d = ST_CLEAR;
            ST_CLEAR:     state_d = ST_REQ;
            ST_REQ:       state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                // An ACK landing on the expiry cycle still counts as success.
                if (PHY_ACK)          state_d = ST_DONE_OK;
                else if (tmr_expired) state_d = retry_left ? ST_REQ : ST_DONE_FAIL;
            end
            ST_DONE_OK:   state_d = ST_IDLE;
            ST_DONE_FAIL: state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        alert_set             = '0;
        alert_set[AL_TX_OK]   = (state_q == ST_DONE_OK);
        alert_set[AL_TX_FAIL] = (state_q == ST_DONE_FAIL);
        alert_set[AL_TX_DISC] = accept_cmd && (state_q != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q             <= ST_IDLE;
            retry_q             <= '0;
            type_q              <= 1'b0;
            alert_q             <= '0;
            oTRANSMIT           <= '0;
            oRECEIVE_DETECT     <= '0;
            oRECEIVE_BYTE_COUNT <= '0;
        end else begin
            state_q <= state_d;
            if (iTRANSMIT_WE) oTRANSMIT <= ioTRANSMIT;
            if ((state_q == ST_IDLE) && accept_cmd) begin
                type_q  <= (ioTRANSMIT[2:0] == CMD_CABLE_RST);
                retry_q <= '0;
            end
            if ((state_q == ST_WAIT_ACK) && !PHY_ACK && tmr_expired && retry_left) begin
                retry_q <= retry_q + 3'd1;
            end
            if (state_q == ST_CLEAR) begin
                oRECEIVE_DETECT     <= '0;
                oRECEIVE_BYTE_COUNT <= '0;
            end
            // Set after clear so a simultaneous set wins.
            alert_q <= ((alert_q & ~iALERT_CLR) | alert_set) & ALERT_USED_MASK;
        end
    end

    assign ALERT                     = alert_q;
    assign PHY_REQ                   = (state_q == ST_REQ);
    assign PHY_REQ_TYPE              = type_q;
    assign PHY_Stop_Attempting_Reset = (state_q == ST_DONE_FAIL);
    assign oBUSY                     = (state_q != ST_IDLE);

endmodule
